// File: rtl/alu_resp_unit_pkg.sv
// Shared definitions for the buffered ALU response unit.
// Holds the Aluc operation encodings used by the ALU and its wrapper.
package alu_resp_unit_pkg;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/alu_resp_unit_alu.sv
// Combinational ALU: add, sub, and, or with a zero flag.
// Ports: X, Y operands; Aluc op select; R result; Z result-is-zero.
module alu_resp_unit_alu
   import alu_resp_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [1:0]       Aluc,
   output logic [WIDTH-1:0] R,
   output logic             Z
);

   // Carry and borrow fall off the top: results wrap mod 2^WIDTH.
   always_comb begin
      R = '0;
      unique case (Aluc)
         ALU_ADD: R = X + Y;
         ALU_SUB: R = X - Y;
         ALU_AND: R = X & Y;
         ALU_OR:  R = X | Y;
         default: R = '0;
      endcase
   end

   assign Z = ~|R;

endmodule

// File: rtl/alu_resp_unit.sv
// ALU with a DEPTH-entry in-order result buffer and valid/ready handshakes.
// Ports: Clk, Clrn (sync active-low); Req_Valid/Req_Ready with X, Y, Aluc in;
//        Rsp_Valid/Rsp_Ready with R, Z out; Count = occupied entries.
module alu_resp_unit
   import alu_resp_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   Clk,
   input  logic                   Clrn,
   input  logic                   Req_Valid,
   output logic                   Req_Ready,
   input  logic [WIDTH-1:0]       X,
   input  logic [WIDTH-1:0]       Y,
   input  logic [1:0]             Aluc,
   output logic                   Rsp_Valid,
   input  logic                   Rsp_Ready,
   output logic [WIDTH-1:0]       R,
   output logic                   Z,
   output logic [$clog2(DEPTH):0] Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] res_mem_q [DEPTH];
   logic             z_mem_q   [DEPTH];

   logic [WIDTH-1:0] alu_r;
   logic             alu_z;

   logic             full;
   logic             empty;
   logic             accept;
   logic             pop;

   alu_resp_unit_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .X    (X),
      .Y    (Y),
      .Aluc (Aluc),
      .R    (alu_r),
      .Z    (alu_z)
   );

   // Ready depends only on the registered count, never on Rsp_Ready,
   // so a full buffer refuses a request even when it is popping.
   assign full      = (cnt_q == CW'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign Req_Ready = ~full;
   assign Rsp_Valid = ~empty;
   assign Count     = cnt_q;

   assign accept    = Req_Valid & ~full;
   assign pop       = Rsp_Ready & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (accept) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({accept, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not cleared; the count alone decides what is live.
   always_ff @(posedge Clk) begin
      if (Clrn && accept) begin
         res_mem_q[wr_ptr_q] <= alu_r;
         z_mem_q[wr_ptr_q]   <= alu_z;
      end
   end

   // Stale storage is masked while empty.
   assign R = empty ? '0 : res_mem_q[rd_ptr_q];
   assign Z = ~empty & z_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_resp_unit.sv
// Scoreboard bench for alu_resp_unit with directed vectors.
// Driver pushes expected responses; a negedge monitor checks the head.
module tb_alu_resp_unit;
   import alu_resp_unit_pkg::*;

   localparam int DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Clrn;
   logic        Req_Valid;
   logic        Req_Ready;
   logic [31:0] X;
   logic [31:0] Y;
   logic [1:0]  Aluc;
   logic        Rsp_Valid;
   logic        Rsp_Ready;
   logic [31:0] R;
   logic        Z;
   logic [2:0]  Count;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_cnt = 0;
   logic [32:0] sb [$];

   always #5 Clk = ~Clk;

   alu_resp_unit #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) dut (
      .Clk       (Clk),
      .Clrn      (Clrn),
      .Req_Valid (Req_Valid),
      .Req_Ready (Req_Ready),
      .X         (X),
      .Y         (Y),
      .Aluc      (Aluc),
      .Rsp_Valid (Rsp_Valid),
      .Rsp_Ready (Rsp_Ready),
      .R         (R),
      .Z         (Z),
      .Count     (Count)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("count", 64'(Count), 64'(exp_cnt));
      chk("req_ready", 64'(Req_Ready), 64'(exp_cnt != DEPTH));
      chk("rsp_valid", 64'(Rsp_Valid), 64'(exp_cnt != 0));
      if (exp_cnt == 0) begin
         chk("empty_r", 64'(R), 64'(0));
         chk("empty_z", 64'(Z), 64'(0));
      end
   endtask

   task automatic cycle(input logic rv, input logic [31:0] x,
                        input logic [31:0] y, input logic [1:0] op,
                        input logic [31:0] er, input logic ez,
                        input logic rr);
      logic acc;
      logic pp;
      @(posedge Clk);
      #1;
      check_state();
      Req_Valid = rv;
      X         = x;
      Y         = y;
      Aluc      = op;
      Rsp_Ready = rr;
      acc = rv && (exp_cnt != DEPTH);
      pp  = rr && (exp_cnt != 0);
      if (acc) sb.push_back({er, ez});
      exp_cnt = exp_cnt + int'(acc) - int'(pp);
   endtask

   task automatic idle(input logic rr);
      cycle(1'b0, 32'h0, 32'h0, ALU_ADD, 32'h0, 1'b0, rr);
   endtask

   task automatic do_reset();
      @(posedge Clk);
      #1;
      check_state();
      Clrn      = 1'b0;
      Req_Valid = 1'b1;
      X         = 32'h7;
      Y         = 32'h1;
      Aluc      = ALU_ADD;
      Rsp_Ready = 1'b0;
      sb.delete();
      exp_cnt = 0;
      @(posedge Clk);
      #1;
      Clrn      = 1'b1;
      Req_Valid = 1'b0;
      check_state();
   endtask

   // Head must match the scoreboard every cycle it is valid, which also
   // covers stability under backpressure.
   always @(negedge Clk) begin
      if (Clrn === 1'b1 && Rsp_Valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got %h/%b expected none", R, Z);
         end else begin
            chk("rsp_r", 64'(R), 64'(sb[0][32:1]));
            chk("rsp_z", 64'(Z), 64'(sb[0][0]));
            if (Rsp_Ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      Clrn      = 1'b0;
      Req_Valid = 1'b0;
      X         = '0;
      Y         = '0;
      Aluc      = ALU_ADD;
      Rsp_Ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Clrn = 1'b1;
      check_state();

      // single AND, one-cycle latency then empty
      cycle(1'b1, 32'hC, 32'hA, ALU_AND, 32'h8, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // zero flag and wrap-around vectors
      cycle(1'b1, 32'h5, 32'h5, ALU_SUB, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'hFFFFFFFF, 32'h1, ALU_ADD, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'hF0, 32'h0F, ALU_OR, 32'hFF, 1'b0, 1'b1);
      cycle(1'b1, 32'h0, 32'h1, ALU_SUB, 32'hFFFFFFFF, 1'b0, 1'b1);
      cycle(1'b1, 32'h7, 32'h8, ALU_ADD, 32'hF, 1'b0, 1'b1);
      cycle(1'b1, 32'hF0, 32'h0F, ALU_AND, 32'h0, 1'b1, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // backpressure: five requests, four fit
      cycle(1'b1, 32'h1, 32'h2, ALU_ADD, 32'h3, 1'b0, 1'b0);
      cycle(1'b1, 32'h10, 32'h3, ALU_SUB, 32'hD, 1'b0, 1'b0);
      cycle(1'b1, 32'hFF, 32'h0F, ALU_AND, 32'hF, 1'b0, 1'b0);
      cycle(1'b1, 32'h100, 32'h1, ALU_OR, 32'h101, 1'b0, 1'b0);
      cycle(1'b1, 32'h9, 32'h9, ALU_ADD, 32'h12, 1'b0, 1'b0);
      idle(1'b0);
      repeat (5) idle(1'b1);

      // full buffer: pop with a refused request on the same edge
      cycle(1'b1, 32'h2, 32'h2, ALU_ADD, 32'h4, 1'b0, 1'b0);
      cycle(1'b1, 32'h8, 32'h8, ALU_SUB, 32'h0, 1'b1, 1'b0);
      cycle(1'b1, 32'hA, 32'h5, ALU_OR, 32'hF, 1'b0, 1'b0);
      cycle(1'b1, 32'h6, 32'h3, ALU_AND, 32'h2, 1'b0, 1'b0);
      cycle(1'b1, 32'h55, 32'h1, ALU_ADD, 32'h56, 1'b0, 1'b1);
      idle(1'b0);
      repeat (4) idle(1'b1);

      // streaming: count holds at 1 and pointers wrap
      cycle(1'b1, 32'h0, 32'h1, ALU_ADD, 32'h1, 1'b0, 1'b1);
      for (int i = 1; i < 10; i++) begin
         cycle(1'b1, 32'(i * 3), 32'h1, ALU_ADD,
               32'(i * 3 + 1), 1'b0, 1'b1);
      end
      idle(1'b1);
      idle(1'b1);

      // reset with three entries in flight and a request pending
      cycle(1'b1, 32'h3, 32'h4, ALU_ADD, 32'h7, 1'b0, 1'b0);
      cycle(1'b1, 32'h3, 32'h1, ALU_SUB, 32'h2, 1'b0, 1'b0);
      cycle(1'b1, 32'h3, 32'h4, ALU_OR, 32'h7, 1'b0, 1'b0);
      idle(1'b0);
      do_reset();
      idle(1'b1);
      idle(1'b1);

      // post-reset sanity
      cycle(1'b1, 32'h20, 32'h22, ALU_ADD, 32'h42, 1'b0, 1'b1);
      idle(1'b1);
      idle(1'b1);

      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_resp_unit.md
ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of result-buffer entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock, all state updates on the rising edge.
REQ-004 The block SHALL have port Clrn, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port Req_Valid, input, 1 bit: a request is present on X, Y and Aluc.
REQ-006 The block SHALL have port Req_Ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 The block SHALL have ports X and Y, inputs, WIDTH bits each: the operands.
REQ-008 The block SHALL have port Aluc, input, 2 bits: the operation select (00 add, 01 sub, 10 and, 11 or).
REQ-009 The block SHALL have port Rsp_Valid, output, 1 bit: R and Z hold a valid response.
REQ-010 The block SHALL have port Rsp_Ready, input, 1 bit: the consumer takes the response this cycle.
REQ-011 The block SHALL have port R, output, WIDTH bits: the result at the buffer head.
REQ-012 The block SHALL have port Z, output, 1 bit: the zero flag at the buffer head.
REQ-013 The block SHALL have port Count, output, clog2(DEPTH)+1 bits: the number of occupied buffer entries.

Function
REQ-014 An accept SHALL occur on a rising edge where Req_Valid and Req_Ready are both 1.
REQ-015 A pop SHALL occur on a rising edge where Rsp_Valid and Rsp_Ready are both 1.
REQ-016 Operations: add = X+Y mod 2^WIDTH; sub = X-Y mod 2^WIDTH; and = bitwise X&Y; or = bitwise X|Y. Carry, borrow and overflow SHALL be discarded.
REQ-017 Z SHALL be 1 exactly when the stored result is all zeros.
REQ-018 On accept, the result and Z SHALL be computed from X, Y and Aluc sampled at that edge and written to the buffer tail; the write pointer SHALL then advance modulo DEPTH.
REQ-019 Latency SHALL be 1 cycle: a response accepted at edge n SHALL be visible on R, Z and Rsp_Valid after edge n, provided the buffer was empty.
REQ-020 Responses SHALL be returned in strict acceptance order.
REQ-021 Req_Ready SHALL be (Count != DEPTH), driven from registered state only; it SHALL have no combinational path from Rsp_Ready.
REQ-022 Rsp_Valid SHALL be (Count != 0).
REQ-023 While Count is 0, R SHALL be 0 and Z SHALL be 0.
REQ-024 R and Z SHALL NOT change while Rsp_Valid=1 and Rsp_Ready=0, i.e. they SHALL stay stable under backpressure.
REQ-025 On a pop, the read pointer SHALL advance modulo DEPTH.
REQ-026 Simultaneous accept and pop SHALL leave Count unchanged and move both pointers; when Count=1 this SHALL present the new result on the next cycle.
REQ-027 When Count=DEPTH, Req_Ready SHALL be 0 and no write SHALL occur even if Req_Valid=1; a pop on that edge SHALL still occur.
REQ-028 When Count=0, Rsp_Ready SHALL be ignored.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 without losing or duplicating any entry.

Reset
REQ-030 When Clrn=0 at a rising edge, Count, both pointers and Rsp_Valid SHALL become 0, Req_Ready SHALL become 1, and R and Z SHALL become 0.
REQ-031 Reset SHALL take priority over a simultaneous accept or pop; in-flight entries SHALL be discarded.
REQ-032 Buffer storage contents need not be cleared on reset.

Structure
REQ-033 A shared package SHALL hold the Aluc encoding constants (ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11).
REQ-034 The existing combinational ALU module (X, Y, Aluc -> R, Z) SHALL be instantiated as the single sub-module; the buffer and control logic SHALL be written inline.

Verification
REQ-035 Reset, then accept X=32'hC, Y=32'hA, Aluc=10 with Rsp_Ready=1 -> next cycle Rsp_Valid=1, R=32'h8, Z=0; one cycle later Rsp_Valid=0.
REQ-036 Accept X=5, Y=5, Aluc=01 -> R=0, Z=1; accept X=32'hFFFFFFFF, Y=1, Aluc=00 -> R=0, Z=1 (carry discarded).
REQ-037 Hold Rsp_Ready=0 and issue 5 requests back-to-back -> 4 accepted, Req_Ready=0 once Count=4, and R and Z stable; then set Rsp_Ready=1 -> the 4 results drain in order.
REQ-038 With Rsp_Ready=1, stream 10 requests continuously -> one accept and one pop every cycle, Count stays at 1, and the pointers wrap with correct ordering.
REQ-039 Reach Count=3, then drive Clrn=0 for one edge while Req_Valid=1 -> Count=0, Rsp_Valid=0, R=0, and no entry is written.
REQ-040 When Count=4, perform a pop and assert Req_Valid on the same edge -> the pop occurs, the request is not accepted, and Count=3.
